conv3d_stream_ctrl: RTL
=======================

// Module: conv3d_stream_ctrl
// PURPOSE
//  Sequencer that feeds one D x H x W volume from voxel memory into the conv3d datapath.
//  Walks addresses raster order (x fastest, then y, then z) and drives conv3d valid_in/voxel_in/last_in.
//  Tracks conv3d results and reports completion and errors to the host.
//  Sits between the voxel SRAM read port and conv3d; one instance per conv3d engine.
// PARAMETERS
//  D        8      volume depth (>=1)
//  H        64     volume height (>=1)
//  W        64     volume width (>=1)
//  DATA_W   8      voxel width, matches conv3d DATA_W
//  ADDR_W   15     memory address width, >= clog2(D*H*W)
//  TIMEOUT  255    DRAIN watchdog limit in cycles (used only with CONV3D_CTRL_DRAIN_TIMEOUT_EN)
// PORTS
//  clk           in   1        clock, all logic rising edge
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        1-cycle pulse, begin a volume; ignored unless IDLE
//  abort         in   1        synchronous abort, any state -> IDLE
//  hold          in   1        stall: no read issued this cycle
//  busy          out  1        high in FETCH and DRAIN
//  done          out  1        1-cycle pulse on volume completion
//  err           out  1        sticky; cleared on accepted start
//  mem_rd_en     out  1        read strobe, registered
//  mem_rd_addr   out  ADDR_W   linear address z*H*W + y*W + x, registered
//  mem_rd_data   in   DATA_W   read data, valid exactly 1 cycle after mem_rd_en
//  conv_voxel    out  DATA_W   to conv3d voxel_in
//  conv_valid    out  1        to conv3d valid_in
//  conv_last     out  1        to conv3d last_in, high with final voxel only
//  conv_valid_out in  1        conv3d valid_out
//  conv_done     in   1        conv3d done
//  out_count     out  ADDR_W+1 number of conv_valid_out pulses this volume
// BEHAVIOUR
//  Reset: state IDLE; every output 0; x/y/z, linear addr, out_count, watchdog cleared.
//  FSM IDLE -> FETCH (start & !abort): clear x/y/z/addr/out_count/err.
//  FETCH: each cycle with hold=0 assert mem_rd_en at current addr, then advance;
//   x wraps W-1->0 and increments y; y wraps H-1->0 and increments z.
//   On issuing addr D*H*W-1 (tag rd_last) -> DRAIN. hold=1: mem_rd_en=0, counters frozen.
//  Data path: conv_valid = mem_rd_en delayed 1 cycle; conv_voxel = mem_rd_data sampled
//   that cycle; conv_last = rd_last delayed 1 cycle. Latency addr->conv_valid: 1 cycle.
//   conv_voxel holds last value when conv_valid=0.
//  out_count increments on every conv_valid_out in FETCH and DRAIN (conv3d may
//   return results while fetch continues).
//  DRAIN: wait for conv_done -> DONE. On conv_done, if out_count (incl. same-cycle
//   conv_valid_out) != D*H*W, set err.
//  DONE: done=1 for one cycle -> IDLE. busy=0 in DONE and IDLE.
//  abort: highest priority; next cycle state IDLE, mem_rd_en=0, conv_valid=0, conv_last=0,
//   no done pulse; abort with start same cycle -> stays IDLE. In-flight read data dropped.
//  start while busy ignored (no counter reset). conv_valid_out/conv_done in IDLE ignored.
//  Volume of 1 voxel (D=H=W=1): first issued read is rd_last; FETCH lasts 1 cycle.
//  rst_n low mid-operation: immediate return to reset values, conv_valid drops asynchronously.
// CONFIGURATION
//  CONV3D_CTRL_DRAIN_TIMEOUT_EN defined: watchdog counts DRAIN cycles from 0; if it reaches
//   TIMEOUT without conv_done, set err and go to DONE (done still pulses once).
//  Not defined: no watchdog logic; DRAIN waits indefinitely for conv_done or abort.
// TESTING
//  D=2,H=3,W=4, start, data=addr -> addr 0..23 on consecutive cycles, conv_valid 24 cycles,
//   conv_last with voxel 23, conv_done after 24 results -> done 1 cycle, err=0, out_count=24.
//  Same volume, hold high at addr 5 for 3 cycles -> addr 5 issued once, conv_valid gap 3 cycles, order intact.
//  start pulse during FETCH at addr 10 -> ignored, sequence continues to 23 unchanged.
//  abort at addr 7 -> next cycle IDLE, mem_rd_en=0, conv_valid=0, no done; new start restarts at addr 0.
//  rst_n low at addr 12 -> all outputs 0 immediately; after release start runs full 0..23.
//  conv_done with only 20 results -> err=1, done pulses; with _EN and no conv_done -> err=1 after TIMEOUT DRAIN cycles.

Source files
------------

// File: rtl/conv3d_stream_ctrl_if.sv
// Bundles the voxel SRAM read port and the conv3d handshake into one interface.
//   master : the stream controller. It drives the read strobe and address and
//            feeds the voxel, valid and last signals to conv3d.
//   slave  : the memory and conv3d side. It returns read data and the conv3d
//            valid_out and done signals.
interface conv3d_stream_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] conv_voxel;
  logic              conv_valid;
  logic              conv_last;
  logic              conv_valid_out;
  logic              conv_done;

  modport master (
    output mem_rd_en, mem_rd_addr, conv_voxel, conv_valid, conv_last,
    input  mem_rd_data, conv_valid_out, conv_done
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, conv_voxel, conv_valid, conv_last,
    output mem_rd_data, conv_valid_out, conv_done
  );
endinterface

// File: rtl/conv3d_stream_ctrl.sv
// conv3d_stream_ctrl: streams one D x H x W volume from voxel memory into conv3d.
// Addresses are walked in raster order: x fastest, then y, then z.
// The block counts conv3d results and reports completion and count errors.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start          1-cycle pulse that starts a volume; only taken in IDLE
//   abort          synchronous abort from any state back to IDLE
//   hold           stall; no read is issued in this cycle
//   busy           high in FETCH and DRAIN
//   done           1-cycle pulse when a volume completes
//   err            sticky count or timeout error; cleared by an accepted start
//   out_count      number of conv3d results seen for this volume
//   bus            conv3d_stream_ctrl_if.master (memory read port and conv3d handshake)
// Build option: define CONV3D_CTRL_DRAIN_TIMEOUT_EN to add a DRAIN watchdog.
//   The watchdog ends DRAIN after TIMEOUT cycles with err set.
module conv3d_stream_ctrl #(
  parameter int D       = 8,
  parameter int H       = 64,
  parameter int W       = 64,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     out_count,
  conv3d_stream_ctrl_if.master bus
);
  localparam int N  = D * H * W;
  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam int ZW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ZW-1:0]     z;
  logic [ADDR_W-1:0] addr, rd_addr;
  logic [1:0]        vld_pipe;   // [0] read issued, [1] voxel presented to conv3d
  logic [1:0]        last_pipe;  // rd_last tag, follows the same stages as vld_pipe
  logic [DATA_W-1:0] voxel_hold;
  logic [ADDR_W:0]   cnt_nxt;
  logic              issue, rd_last, count_en, err_set, start_ok;

`ifdef CONV3D_CTRL_DRAIN_TIMEOUT_EN
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WDW-1:0] wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wd <= '0;
    else if (state == DRAIN) wd <= wd + WDW'(1);
    else                     wd <= '0;
  end
`endif

  assign rd_last = (x == XW'(W - 1)) && (y == YW'(H - 1)) && (z == ZW'(D - 1));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    err_set   = 1'b0;
    start_ok  = 1'b0;
    // Results are counted while a volume is active. Counting stops on abort.
    count_en  = ((state == FETCH) || (state == DRAIN)) && bus.conv_valid_out && !abort;
    cnt_nxt   = out_count + (ADDR_W + 1)'(count_en);
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start) begin
                 state_nxt = FETCH;
                 start_ok  = 1'b1;
               end
        FETCH: if (!hold) begin
                 issue = 1'b1;
                 if (rd_last) state_nxt = DRAIN;
               end
        DRAIN: if (bus.conv_done) begin
                 state_nxt = DONE;
                 // The count includes a result that arrives in the same cycle.
                 err_set   = (cnt_nxt != (ADDR_W + 1)'(N));
               end
`ifdef CONV3D_CTRL_DRAIN_TIMEOUT_EN
               else if (wd == WDW'(TIMEOUT - 1)) begin
                 state_nxt = DONE;
                 err_set   = 1'b1;
               end
`endif
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      addr       <= '0;
      rd_addr    <= '0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      voxel_hold <= '0;
      out_count  <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start_ok) begin
        x    <= '0;
        y    <= '0;
        z    <= '0;
        addr <= '0;
      end else if (issue) begin
        addr <= addr + ADDR_W'(1);
        if (x == XW'(W - 1)) begin
          x <= '0;
          if (y == YW'(H - 1)) begin
            y <= '0;
            z <= z + ZW'(1);
          end else begin
            y <= y + YW'(1);
          end
        end else begin
          x <= x + XW'(1);
        end
      end

      if (issue) rd_addr <= addr;
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue && rd_last;
      // On abort, a read that is still in flight is not passed to conv3d.
      vld_pipe[1]  <= vld_pipe[0] && !abort;
      last_pipe[1] <= last_pipe[0] && !abort;
      if (vld_pipe[1]) voxel_hold <= bus.mem_rd_data;

      if (start_ok) out_count <= '0;
      else          out_count <= cnt_nxt;

      if (start_ok)     err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  // Read data arrives in the same cycle as vld_pipe[1], so it passes straight through.
  // The last voxel is held while there is no valid voxel.
  assign bus.conv_voxel  = vld_pipe[1] ? bus.mem_rd_data : voxel_hold;
  assign bus.conv_valid  = vld_pipe[1];
  assign bus.conv_last   = last_pipe[1];
  assign bus.mem_rd_en   = vld_pipe[0];
  assign bus.mem_rd_addr = rd_addr;
  assign busy            = (state == FETCH) || (state == DRAIN);
  assign done            = (state == DONE);
endmodule
